// File: rtl/pixel_writer.sv
// Pixel writer: accepts (x,y) pixels from a line generator, drops
// repeated coordinates, and streams {address, colour} writes through a
// small FIFO to a framebuffer write port with req/ack handshaking.
// Optional feature: define PIXEL_CLIP_EN to discard off-screen pixels
// and count them on drop_count. Without it no pixel is clipped and
// drop_count is tied to zero.
module pixel_writer #(
  parameter int unsigned size       = 16,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color,
  input  logic              pix_valid,
  input  logic [size-1:0]   x,
  input  logic [size-1:0]   y,
  input  logic              gen_done,
  output logic              pix_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [15:0]       drop_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] HResA = ADDR_W'(H_RES);

  // Pointer wrap relies on a power-of-two depth; the frame must fit the address space.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      ((longint'(H_RES) * longint'(V_RES)) > (longint'(1) << ADDR_W))) begin : g_bad_cfg
    $error("pixel_writer: illegal FIFO_DEPTH or frame larger than ADDR_W space");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] color_q;
  logic [size-1:0]   last_x_q, last_y_q;
  logic              last_vld_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              fifo_full, fifo_empty;
  logic              accept, clipped, keep, is_dup, push, pop;
  logic [ADDR_W-1:0] pix_addr;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign pix_ready = (state_q == StRun) && !fifo_full;
  assign accept    = pix_ready && pix_valid;
  assign is_dup    = last_vld_q && (x == last_x_q) && (y == last_y_q);
  assign keep      = accept && !clipped;
  assign push      = keep && !is_dup;
  assign pop       = mem_req && mem_ack;

  // Signed coordinates are sign-extended so negative values wrap modulo 2^ADDR_W.
  assign pix_addr = ADDR_W'($signed(y)) * HResA + ADDR_W'($signed(x));

  assign mem_req  = !fifo_empty;
  // Outputs read zero while empty so reset clears them without resetting storage.
  assign mem_addr = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
  assign mem_data = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

`ifdef PIXEL_CLIP_EN
  localparam logic [size-1:0] HResX = size'(H_RES);
  localparam logic [size-1:0] VResY = size'(V_RES);

  logic [15:0] drop_q;

  // Sign bit catches negatives; unsigned compare catches the far edges.
  assign clipped = x[size-1] || y[size-1] || (x >= HResX) || (y >= VResY);

  // Saturating count of clipped pixels, cleared when a new line starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      drop_q <= '0;
    end else if (accept && clipped && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign clipped    = 1'b0;
  assign drop_count = '0;
`endif

  // Line control FSM plus latched colour and dedup history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      color_q    <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      last_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            color_q    <= color;
            last_vld_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (keep) begin
            last_x_q   <= x;
            last_y_q   <= y;
            last_vld_q <= 1'b1;
          end
          if (gen_done) state_q <= StDrain;
        end
        // mem_req is exactly "FIFO non-empty", so empty implies no write in flight.
        StDrain: if (fifo_empty) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= pix_addr;
      fifo_data_q[wr_ptr_q] <= color_q;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: table-driven pixel lines with a
// write scoreboard, plus hand sequences for backpressure, mid-drain reset
// and (when PIXEL_CLIP_EN is defined) clipping.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pix_valid, gen_done, mem_ack;
  logic [7:0]  color;
  logic [15:0] x, y;
  logic        pix_ready, mem_req, busy, done;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic [15:0] drop_count;

  int tests  = 0;
  int failed = 0;
  int done_cnt = 0;
  logic [26:0] exp_q [$];

  typedef struct {
    bit          first;
    bit          last;
    bit          glitch;
    logic [7:0]  col;
    logic [15:0] px;
    logic [15:0] py;
    bit          wr;
    logic [18:0] addr;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] cur_col;

  pixel_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .color      (color),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .gen_done   (gen_done),
    .pix_ready  (pix_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a write is taken when req and ack are both high at the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_write: got addr %0d required no write", mem_addr);
        end else begin
          logic [26:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {13'd0, mem_addr}, {13'd0, e[26:8]});
          check("wr_data", {24'd0, mem_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic start_line(input logic [7:0] c);
    start = 1'b1;
    color = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic glitch_start();
    start = 1'b1;
    color = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pix(input logic [15:0] px, input logic [15:0] py);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    x = px;
    y = py;
    pix_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
    end
    pix_valid = 1'b0;
    check("pix_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic finish_line(input logic [15:0] exp_drop);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    gen_done = 1'b1;
    @(posedge clk); #1;
    gen_done = 1'b0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("done_pulses", done_cnt - d0, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);
    check("drop_count", {16'd0, drop_count}, {16'd0, exp_drop});
  endtask

  initial begin
    // first last glitch col x y wr addr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h3C, 16'd0,   16'd0,   1'b1, 19'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h3C, 16'd1,   16'd0,   1'b1, 19'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 16'd2,   16'd1,   1'b1, 19'd642};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 16'd5,   16'd5,   1'b1, 19'd3205};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h5A, 16'd5,   16'd5,   1'b0, 19'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h5A, 16'd6,   16'd5,   1'b1, 19'd3206};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 16'd6,   16'd5,   1'b1, 19'd3206};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 16'd6,   16'd6,   1'b1, 19'd3846};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 16'd6,   16'd6,   1'b0, 19'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 16'd639, 16'd479, 1'b1, 19'd307199};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h11, 16'd10,  16'd0,   1'b1, 19'd10};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h11, 16'd0,   16'd10,  1'b1, 19'd6400};

    rst_n = 1'b0;
    start = 1'b0;
    color = 8'h00;
    pix_valid = 1'b0;
    x = '0;
    y = '0;
    gen_done = 1'b0;
    mem_ack = 1'b1;
    cur_col = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_mem_addr",  {13'd0, mem_addr},  32'd0);
    check("rst_mem_data",  {24'd0, mem_data},  32'd0);
    check("rst_drop",      {16'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven lines with ack always high.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].first) begin
        start_line(vecs[i].col);
        cur_col = vecs[i].col;
        @(negedge clk);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
      end
      if (vecs[i].glitch) glitch_start();
      if (vecs[i].wr) exp_q.push_back({vecs[i].addr, cur_col});
      drive_pix(vecs[i].px, vecs[i].py);
      if (vecs[i].last) finish_line(16'd0);
    end

`ifdef PIXEL_CLIP_EN
    // Off-screen pixels dropped and counted; only (2,2) is written.
    start_line(8'h66);
    drive_pix(16'hFFFF, 16'd3);
    drive_pix(16'd640, 16'd0);
    drive_pix(16'd10, 16'd480);
    exp_q.push_back({19'd1282, 8'h66});
    drive_pix(16'd2, 16'd2);
    finish_line(16'd3);
`else
    // No clipping: out-of-range coordinates wrap through the address product.
    start_line(8'h66);
    exp_q.push_back({19'd640, 8'h66});
    drive_pix(16'd640, 16'd0);
    exp_q.push_back({19'd639, 8'h66});
    drive_pix(16'hFFFF, 16'd1);
    finish_line(16'd0);
`endif

    // Backpressure: ack held low, FIFO fills after four pixels.
    mem_ack = 1'b0;
    start_line(8'hC3);
    exp_q.push_back({19'd660, 8'hC3});
    drive_pix(16'd20, 16'd1);
    @(negedge clk);
    check("latency_req",  {31'd0, mem_req},  32'd1);
    check("latency_addr", {13'd0, mem_addr}, 32'd660);
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++) begin
      exp_q.push_back({19'(660 + k), 8'hC3});
      drive_pix(16'(20 + k), 16'd1);
    end
    x = 16'd24;
    y = 16'd1;
    pix_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_ready", {31'd0, pix_ready}, 32'd0);
      check("held_addr",  {13'd0, mem_addr},  32'd660);
      check("held_req",   {31'd0, mem_req},   32'd1);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    exp_q.push_back({19'd664, 8'hC3});
    drive_pix(16'd24, 16'd1);
    exp_q.push_back({19'd665, 8'hC3});
    drive_pix(16'd25, 16'd1);
    finish_line(16'd0);

    // Reset while draining with three entries queued.
    begin
      int d0;
      mem_ack = 1'b0;
      start_line(8'h77);
      drive_pix(16'd1, 16'd1);
      drive_pix(16'd2, 16'd1);
      drive_pix(16'd3, 16'd1);
      gen_done = 1'b1;
      @(posedge clk); #1;
      gen_done = 1'b0;
      @(negedge clk);
      check("drain_busy", {31'd0, busy},    32'd1);
      check("drain_req",  {31'd0, mem_req}, 32'd1);
      @(posedge clk); #3;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("arst_req",   {31'd0, mem_req},   32'd0);
      check("arst_busy",  {31'd0, busy},      32'd0);
      check("arst_ready", {31'd0, pix_ready}, 32'd0);
      check("arst_addr",  {13'd0, mem_addr},  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      color = 8'h42;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("restart_busy", {31'd0, busy}, 32'd1);
      check("no_done_rst",  done_cnt - d0, 32'd0);
      @(posedge clk); #1;
      exp_q.push_back({19'd3, 8'h42});
      drive_pix(16'd3, 16'd0);
      finish_line(16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
